// File: rtl/hockey_match_ctrl_if.sv
// Signal bundle between the match sequencer and its environment.
// The player buttons and core goal pulses go in; match flow, scores and winner come out.
interface hockey_match_ctrl_if #(
  parameter int SCORE_W = 3
);
  logic               BTNA;
  logic               BTNB;
  logic               goal_a;
  logic               goal_b;
  logic               core_en;
  logic               round_start;
  logic               serve_a;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport master (
    output BTNA, BTNB, goal_a, goal_b,
    input  core_en, round_start, serve_a, score_a, score_b, winner, state_o
  );

  modport slave (
    input  BTNA, BTNB, goal_a, goal_b,
    output core_en, round_start, serve_a, score_a, score_b, winner, state_o
  );
endinterface

// File: rtl/hockey_match_ctrl.sv
// Match sequencer above the hockey core: serve/play/show/game-over flow,
// button edge detection, goal counting, serve alternation and winner detection.
module hockey_match_ctrl #(
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 3,
  parameter int SHOW_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  hockey_match_ctrl_if.slave  bus
);
  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SERVE = 3'd1,
    PLAY       = 3'd2,
    SHOW       = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_prev_a, r_prev_b;
  logic               r_core_en, w_core_en_next;
  logic               r_round_start, w_round_start_next;
  logic               r_serve_a, w_serve_a_next;
  logic [SCORE_W-1:0] r_score_a, w_score_a_next;
  logic [SCORE_W-1:0] r_score_b, w_score_b_next;
  logic [1:0]         r_winner, w_winner_next;
  logic [CNT_W-1:0]   r_show_cnt, w_show_cnt_next;

  logic               w_rise_a, w_rise_b;
  logic [SCORE_W-1:0] w_inc_a, w_inc_b;

  assign w_rise_a = bus.BTNA & ~r_prev_a;
  assign w_rise_b = bus.BTNB & ~r_prev_b;
  assign w_inc_a  = r_score_a + SCORE_W'(1);
  assign w_inc_b  = r_score_b + SCORE_W'(1);

  // History resets high so a button held through reset produces no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_prev_a      <= 1'b1;
      r_prev_b      <= 1'b1;
      r_core_en     <= 1'b0;
      r_round_start <= 1'b0;
      r_serve_a     <= 1'b1;
      r_score_a     <= '0;
      r_score_b     <= '0;
      r_winner      <= 2'b00;
      r_show_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_prev_a      <= bus.BTNA;
      r_prev_b      <= bus.BTNB;
      r_core_en     <= w_core_en_next;
      r_round_start <= w_round_start_next;
      r_serve_a     <= w_serve_a_next;
      r_score_a     <= w_score_a_next;
      r_score_b     <= w_score_b_next;
      r_winner      <= w_winner_next;
      r_show_cnt    <= w_show_cnt_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_round_start_next = 1'b0;
    w_serve_a_next     = r_serve_a;
    w_score_a_next     = r_score_a;
    w_score_b_next     = r_score_b;
    w_winner_next      = r_winner;
    w_show_cnt_next    = r_show_cnt;

    case (r_state)
      IDLE: begin
        if (w_rise_a | w_rise_b) begin
          w_state_next   = WAIT_SERVE;
          w_serve_a_next = 1'b1;
        end
      end
      WAIT_SERVE: begin
        if (r_serve_a ? w_rise_a : w_rise_b) begin
          w_state_next       = PLAY;
          w_round_start_next = 1'b1;
        end
      end
      PLAY: begin
        // Simultaneous goals are treated as a glitch and ignored.
        if (bus.goal_a && !bus.goal_b) begin
          w_score_a_next = w_inc_a;
          w_serve_a_next = 1'b0;
          if (w_inc_a == WIN) begin
            w_state_next  = GAME_OVER;
            w_winner_next = 2'b01;
          end else begin
            w_state_next    = SHOW;
            w_show_cnt_next = SHOW_LOAD;
          end
        end else if (bus.goal_b && !bus.goal_a) begin
          w_score_b_next = w_inc_b;
          w_serve_a_next = 1'b1;
          if (w_inc_b == WIN) begin
            w_state_next  = GAME_OVER;
            w_winner_next = 2'b10;
          end else begin
            w_state_next    = SHOW;
            w_show_cnt_next = SHOW_LOAD;
          end
        end
      end
      SHOW: begin
        if (r_show_cnt == '0) w_state_next = WAIT_SERVE;
        else                  w_show_cnt_next = r_show_cnt - CNT_W'(1);
      end
      GAME_OVER: begin
        if (w_rise_a | w_rise_b) begin
          w_state_next   = IDLE;
          w_score_a_next = '0;
          w_score_b_next = '0;
          w_winner_next  = 2'b00;
          w_serve_a_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_core_en_next = (w_state_next == PLAY);
  end

  assign bus.core_en     = r_core_en;
  assign bus.round_start = r_round_start;
  assign bus.serve_a     = r_serve_a;
  assign bus.score_a     = r_score_a;
  assign bus.score_b     = r_score_b;
  assign bus.winner      = r_winner;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_hockey_match_ctrl.sv
// Scoreboard bench for hockey_match_ctrl: directed per-cycle stimulus pushes
// hand-computed expected outputs; a negedge monitor pops and compares them.
module tb_hockey_match_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hockey_match_ctrl_if #(.SCORE_W(3)) bus ();

  hockey_match_ctrl #(
    .WIN_SCORE  (3),
    .SCORE_W    (3),
    .SHOW_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ce;
    logic       rs;
    logic       sa;
    logic [2:0] sca;
    logic [2:0] scb;
    logic [1:0] w;
  } exp_t;

  typedef struct {
    int    cyc;
    exp_t  exp;
    string name;
  } sb_item_t;

  sb_item_t sb_q[$];

  // Inputs for one cycle plus the outputs expected right after that cycle's edge.
  task automatic step(input logic a, b, ga, gb, r,
                      input logic [2:0] st, input logic ce, rs, sa,
                      input logic [2:0] sca, scb, input logic [1:0] w,
                      input string nm);
    sb_item_t it;
    @(posedge clk);
    #1;
    bus.BTNA = a; bus.BTNB = b; bus.goal_a = ga; bus.goal_b = gb; rst = r;
    it.cyc = cyc + 1;
    it.exp = '{st: st, ce: ce, rs: rs, sa: sa, sca: sca, scb: scb, w: w};
    it.name = nm;
    sb_q.push_back(it);
  endtask

  always @(negedge clk) begin
    sb_item_t it;
    exp_t got;
    got.st = bus.state_o; got.ce = bus.core_en; got.rs = bus.round_start;
    got.sa = bus.serve_a; got.sca = bus.score_a; got.scb = bus.score_b;
    got.w = bus.winner;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      it = sb_q.pop_front();
      checks++;
      if (it.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", it.name, it.cyc, cyc);
      end else if (got !== it.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d: got st=%0d ce=%b rs=%b sa=%b A=%0d B=%0d w=%b, required st=%0d ce=%b rs=%b sa=%b A=%0d B=%0d w=%b",
                 it.name, cyc, got.st, got.ce, got.rs, got.sa, got.sca, got.scb, got.w,
                 it.exp.st, it.exp.ce, it.exp.rs, it.exp.sa, it.exp.sca, it.exp.scb, it.exp.w);
      end else begin
        $display("ok   %s cyc=%0d st=%0d ce=%b rs=%b sa=%b A=%0d B=%0d w=%b",
                 it.name, cyc, got.st, got.ce, got.rs, got.sa, got.sca, got.scb, got.w);
      end
    end
  end

  initial begin
    bus.BTNA = 1'b0; bus.BTNB = 1'b0; bus.goal_a = 1'b0; bus.goal_b = 1'b0;
    //    a  b  ga gb r    st ce rs sa A  B  w
    step(0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "reset0");
    step(0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "reset1");
    step(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "idle");
    step(1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "idle_riseA");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "wait");
    step(0, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "wait_riseB_ignored");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "wait");
    step(1, 0, 0, 0, 0,   2, 1, 1, 1, 0, 0, 2'b00, "serveA_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 2'b00, "play_rs_one_cycle");
    step(1, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 2'b00, "play_btn_ignored");
    step(0, 0, 1, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "goalA_1");
    step(0, 1, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show1_btn_discard");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show2");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show3");
    step(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 2'b00, "show_exit");
    step(1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 2'b00, "wait_riseA_ignored");
    step(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 2'b00, "wait");
    step(0, 1, 0, 0, 0,   2, 1, 1, 0, 1, 0, 2'b00, "serveB_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 2'b00, "play");
    step(0, 0, 1, 1, 0,   2, 1, 0, 0, 1, 0, 2'b00, "both_goals_ignored");
    step(0, 0, 0, 1, 0,   3, 0, 0, 1, 1, 1, 2'b00, "goalB_1");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 1, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 1, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 1, 2'b00, "show");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 1, 2'b00, "show_exit");
    step(1, 0, 0, 0, 0,   2, 1, 1, 1, 1, 1, 2'b00, "serveA_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 1, 1, 1, 2'b00, "play");
    step(0, 0, 0, 1, 0,   3, 0, 0, 1, 1, 2, 2'b00, "goalB_2");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 2, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 2, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 1, 1, 2, 2'b00, "show");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2, 2'b00, "show_exit");
    step(1, 0, 0, 0, 0,   2, 1, 1, 1, 1, 2, 2'b00, "serveA_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 1, 1, 2, 2'b00, "play");
    step(0, 0, 0, 1, 0,   4, 0, 0, 1, 1, 3, 2'b10, "goalB_win");
    step(0, 0, 0, 1, 0,   4, 0, 0, 1, 1, 3, 2'b10, "gameover_goal_ignored");
    step(0, 0, 0, 0, 0,   4, 0, 0, 1, 1, 3, 2'b10, "gameover_hold");
    step(1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "gameover_riseA_clear");
    step(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "idle");
    step(1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "hold_rst0");
    step(1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "hold_rst1");
    step(1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "held_no_edge0");
    step(1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "held_no_edge1");
    step(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "release");
    step(1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "new_riseA");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "wait");
    step(1, 0, 0, 0, 0,   2, 1, 1, 1, 0, 0, 2'b00, "serveA_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0, 2'b00, "play");
    step(0, 0, 1, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "goalA_1");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 1, 0, 2'b00, "show");
    step(0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 2'b00, "show_exit");
    step(0, 1, 0, 0, 0,   2, 1, 1, 0, 1, 0, 2'b00, "serveB_round_start");
    step(0, 0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 2'b00, "play");
    step(0, 0, 1, 0, 0,   3, 0, 0, 0, 2, 0, 2'b00, "goalA_2");
    step(0, 0, 0, 0, 0,   3, 0, 0, 0, 2, 0, 2'b00, "show");
    step(0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "rst_in_show");
    step(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "idle_after_rst");
    step(1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "idle_riseA");
    step(0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 2'b00, "wait");
    step(1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2'b00, "rst_cancels_serve");
    step(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 2'b00, "idle_final");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hockey_match_ctrl.md
Name: hockey_match_ctrl

Overview:
Match sequencer that sits above the hockey game core. It owns match flow (idle, serve, play, score display, game over) and decides when the core may advance and who serves. It conditions the BTNA/BTNB player buttons into rising-edge events, counts goals reported by the core, alternates the serve to the conceding player, and declares a winner at WIN_SCORE.

Parameters:
WIN_SCORE, 3, goals needed to win; must be <= 2^SCORE_W-1
SCORE_W, 3, width of each score counter
SHOW_CYCLES, 4, clock cycles the core is held frozen after a goal before the next serve; >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
BTNA  in  1  player A button, level
BTNB  in  1  player B button, level
goal_a  in  1  core pulse: A scored (puck crossed B's goal line)
goal_b  in  1  core pulse: B scored
core_en  out  1  core may advance puck and paddles
round_start  out  1  one-cycle pulse: core reloads puck at server's side
serve_a  out  1  1 = A serves current/next round, 0 = B
score_a  out  SCORE_W  A's goals
score_b  out  SCORE_W  B's goals
winner  out  2  00 none, 01 A, 10 B (11 never driven)
state_o  out  3  current state encoding, for debug/display

Behaviour:
- Only clk is used. rst is synchronous and active-high, sampled on the clk rising edge. All outputs are registered.
- Reset values:
  - state IDLE (0), core_en 0, round_start 0, serve_a 1.
  - score_a 0, score_b 0, winner 00.
  - Button history registers reset to 1, so a button held through reset gives no edge.
- Edge detect: riseA = BTNA & ~prevA, likewise riseB. prev is updated every cycle in every state. A held button yields exactly one rise.
- Latency: an input sampled at edge N changes outputs after edge N (visible in cycle N+1).
- States (state_o encoding):
  - IDLE=0, WAIT_SERVE=1, PLAY=2, SHOW=3, GAME_OVER=4. Encodings 5-7 are unreachable; if entered, go to IDLE.
- IDLE:
  - core_en 0.
  - riseA or riseB -> WAIT_SERVE with serve_a=1 (A always opens).
- WAIT_SERVE:
  - core_en 0.
  - Only the server's rise is honoured; the other button is ignored.
  - On the server's rise: round_start=1 for exactly one cycle, core_en=1 in the same cycle, go to PLAY.
- PLAY:
  - core_en 1.
  - goal_a alone: score_a+1, serve_a<=0 (the conceding player serves next).
  - goal_b alone: score_b+1, serve_a<=1.
  - goal_a and goal_b in the same cycle: both ignored, no score change, stay in PLAY.
  - After a counted goal: if the new score == WIN_SCORE, go to GAME_OVER with winner set (01 for A, 10 for B). Otherwise go to SHOW.
  - core_en drops to 0 in the cycle after the goal cycle.
- SHOW:
  - core_en 0. Internal counter loads SHOW_CYCLES-1 on entry, decrements each cycle, and exits to WAIT_SERVE at 0, so SHOW lasts exactly SHOW_CYCLES cycles.
  - Button rises during SHOW are discarded; the server must press again in WAIT_SERVE.
- GAME_OVER:
  - core_en 0. Scores and winner are held.
  - riseA or riseB -> IDLE, clearing scores, winner=00, serve_a=1.
- goal_a/goal_b outside PLAY are ignored.
- Scores never wrap; they cannot exceed WIN_SCORE.
- rst asserted in any state, mid-round or mid-SHOW, restores all reset values on that edge. Any pending round_start is cancelled.

Test Plan:
- Reset, then BTNA rise -> state 1, serve_a=1. BTNB rise -> no change. BTNA rise -> round_start high exactly 1 cycle, core_en=1, state 2.
- In PLAY, pulse goal_a -> score_a=1, serve_a=0, state 3. core_en stays 0 for exactly 4 cycles, then state 1. BTNA rise is ignored; BTNB rise starts the next round.
- goal_a and goal_b asserted in the same PLAY cycle -> scores unchanged, state stays 2, core_en stays 1.
- Drive B to 3 goals (pulse goal_b three times across rounds) -> score_b=3, winner=10, state 4, core_en 0. A further goal_b has no effect. BTNA rise -> state 0, scores 0, winner 00, serve_a 1.
- Hold BTNA high across reset and release of rst -> no transition out of IDLE until BTNA falls and rises again.
- Assert rst during SHOW with score_a=2 -> next cycle: state 0, scores 0, core_en 0, round_start 0, serve_a 1.
